// File: rtl/cwc_capture_pkg.sv
// Shared definitions for the capture controller: FSM state type, default
// sizing and address/fill-width helpers.
package cwc_capture_pkg;

  // Default sizing: one full probe bus per sample, 16K-deep capture RAM.
  localparam int DATA_W_DEF = 90;
  localparam int ADDR_W_DEF = 14;
  localparam int DEPTH_DEF  = 2 ** ADDR_W_DEF;
  // fill_cnt needs one extra bit so it can represent a completely full RAM.
  localparam int FILL_W_DEF = ADDR_W_DEF + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } cap_state_t;

endpackage

// File: rtl/cwc_capture_if.sv
// Capture RAM write port. master = capture controller, slave = the RAM.
interface cwc_capture_if
  import cwc_capture_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) ();

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;

  modport master (
    output ram_we,
    output ram_waddr,
    output ram_wdata
  );

  modport slave (
    input ram_we,
    input ram_waddr,
    input ram_wdata
  );

endinterface

// File: rtl/cwc_wrap_cnt.sv
// Write-address counter: ADDR_W bits wide, wraps naturally from
// 2**ADDR_W-1 back to 0. Clear has priority over enable.
module cwc_wrap_cnt #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  output logic [ADDR_W-1:0] cnt
);

  logic [ADDR_W-1:0] cnt_reg;

  // Counter register: clear on a new capture, advance once per RAM write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= cnt_reg + ADDR_W'(1);
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/cwc_capture_ctrl.sv
// Logic-analyser style capture controller. Streams din into a circular
// capture RAM while armed, stops a programmable number of samples after the
// trigger, and reports where the trigger and the oldest sample landed.
// Optional build macro: CWC_CAPTURE_QUAL_EN adds a 'qual' input; only
// qualified cycles write, advance addresses/counters, or accept a trigger.
module cwc_capture_ctrl
  import cwc_capture_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef CWC_CAPTURE_QUAL_EN
  input  logic              qual,
`endif
  input  logic              arm,
  input  logic              abort,
  input  logic              trig,
  input  logic [ADDR_W-1:0] post_len,
  input  logic [DATA_W-1:0] din,
  cwc_capture_if.master     ram,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] trig_addr,
  output logic [ADDR_W-1:0] start_addr,
  output logic [ADDR_W:0]   fill_cnt
);

  localparam int                 DEPTH    = 2 ** ADDR_W;
  localparam int                 FILL_W   = ADDR_W + 1;
  localparam logic [FILL_W-1:0]  DEPTH_F  = FILL_W'(DEPTH);
  localparam logic [ADDR_W-1:0]  MAX_POST = ADDR_W'(DEPTH - 1);

  cap_state_t        state_reg, state_next;
  logic [ADDR_W-1:0] post_len_reg, post_len_next;
  logic [ADDR_W-1:0] post_cnt_reg, post_cnt_next;
  logic              ram_we_reg, ram_we_next;
  logic [ADDR_W-1:0] ram_waddr_reg, ram_waddr_next;
  logic [DATA_W-1:0] ram_wdata_reg, ram_wdata_next;
  logic [ADDR_W-1:0] trig_addr_reg, trig_addr_next;
  logic [ADDR_W-1:0] start_addr_reg, start_addr_next;
  logic [FILL_W-1:0] fill_cnt_reg, fill_cnt_next;

  logic              qual_ok;
  logic              active;
  logic              arm_ok;
  logic              wr_fire;
  logic              trig_hit;
  logic              post_last;
  logic [ADDR_W-1:0] waddr;
  logic [FILL_W-1:0] fill_inc;
  logic [ADDR_W-1:0] post_len_clamped;

`ifdef CWC_CAPTURE_QUAL_EN
  assign qual_ok = qual;
`else
  assign qual_ok = 1'b1;
`endif

  // A new arm is only honoured when no capture is running; abort always
  // suppresses the write of its own cycle, which gives it priority over a
  // coincident trigger or the final POST sample.
  assign active    = (state_reg == ST_ARMED) || (state_reg == ST_POST);
  assign arm_ok    = arm && !active;
  assign wr_fire   = active && !abort && qual_ok;
  assign trig_hit  = (state_reg == ST_ARMED) && trig && wr_fire;
  assign post_last = (state_reg == ST_POST) && wr_fire && (post_cnt_reg == ADDR_W'(1));

  // post_len is only ADDR_W wide today, but keep the clamp so a future
  // wider post_len cannot ask for more samples than the RAM holds.
  assign post_len_clamped = (post_len > MAX_POST) ? MAX_POST : post_len;

  assign fill_inc = (fill_cnt_reg == DEPTH_F) ? DEPTH_F : (fill_cnt_reg + FILL_W'(1));

  cwc_wrap_cnt #(
    .ADDR_W(ADDR_W)
  ) u_waddr_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (arm_ok),
    .en   (wr_fire),
    .cnt  (waddr)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: abort wins over trigger/end-of-POST while busy.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (arm) state_next = ST_ARMED;
      end
      ST_ARMED: begin
        if (abort) begin
          state_next = ST_IDLE;
        end else if (trig_hit) begin
          state_next = (post_len_reg == '0) ? ST_DONE : ST_POST;
        end
      end
      ST_POST: begin
        if (abort) begin
          state_next = ST_IDLE;
        end else if (post_last) begin
          state_next = ST_DONE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath next values: write stage, result registers and POST countdown.
  always_comb begin
    post_len_next   = post_len_reg;
    post_cnt_next   = post_cnt_reg;
    ram_we_next     = wr_fire;
    ram_waddr_next  = ram_waddr_reg;
    ram_wdata_next  = ram_wdata_reg;
    trig_addr_next  = trig_addr_reg;
    start_addr_next = start_addr_reg;
    fill_cnt_next   = fill_cnt_reg;

    if (arm_ok) begin
      post_len_next   = post_len_clamped;
      fill_cnt_next   = '0;
      trig_addr_next  = '0;
      start_addr_next = '0;
    end

    if (wr_fire) begin
      ram_waddr_next = waddr;
      ram_wdata_next = din;
      fill_cnt_next  = fill_inc;
      // Once the RAM is full the oldest sample sits just past the newest.
      if (fill_inc == DEPTH_F) begin
        start_addr_next = waddr + ADDR_W'(1);
      end
    end

    if (trig_hit) begin
      trig_addr_next = waddr;
      post_cnt_next  = post_len_reg;
    end else if ((state_reg == ST_POST) && wr_fire) begin
      post_cnt_next = post_cnt_reg - ADDR_W'(1);
    end
  end

  // Datapath registers, including the single write-port register stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      post_len_reg   <= '0;
      post_cnt_reg   <= '0;
      ram_we_reg     <= 1'b0;
      ram_waddr_reg  <= '0;
      ram_wdata_reg  <= '0;
      trig_addr_reg  <= '0;
      start_addr_reg <= '0;
      fill_cnt_reg   <= '0;
    end else begin
      post_len_reg   <= post_len_next;
      post_cnt_reg   <= post_cnt_next;
      ram_we_reg     <= ram_we_next;
      ram_waddr_reg  <= ram_waddr_next;
      ram_wdata_reg  <= ram_wdata_next;
      trig_addr_reg  <= trig_addr_next;
      start_addr_reg <= start_addr_next;
      fill_cnt_reg   <= fill_cnt_next;
    end
  end

  assign ram.ram_we    = ram_we_reg;
  assign ram.ram_waddr = ram_waddr_reg;
  assign ram.ram_wdata = ram_wdata_reg;

  assign busy       = active;
  assign done       = (state_reg == ST_DONE);
  assign trig_addr  = trig_addr_reg;
  assign start_addr = start_addr_reg;
  assign fill_cnt   = fill_cnt_reg;

endmodule

// File: tb/tb_cwc_capture_ctrl.sv
// Bench for cwc_capture_ctrl. Stimulus pushes each expected RAM write into a
// queue; a negedge monitor pops and compares every ram_we it sees. Status
// outputs are compared against hand-computed values after each scenario.
module tb_cwc_capture_ctrl;
  import cwc_capture_pkg::*;

  localparam int DW = 90;
  localparam int AW = 14;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b1;
  logic          arm      = 1'b0;
  logic          abort    = 1'b0;
  logic          trig     = 1'b0;
  logic [AW-1:0] post_len = '0;
  logic [DW-1:0] din      = '0;
`ifdef CWC_CAPTURE_QUAL_EN
  logic          qual     = 1'b1;
`endif
  logic          busy;
  logic          done;
  logic [AW-1:0] trig_addr;
  logic [AW-1:0] start_addr;
  logic [AW:0]   fill_cnt;

  cwc_capture_if #(.DATA_W(DW), .ADDR_W(AW)) ram_if ();

  cwc_capture_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef CWC_CAPTURE_QUAL_EN
    .qual      (qual),
`endif
    .arm       (arm),
    .abort     (abort),
    .trig      (trig),
    .post_len  (post_len),
    .din       (din),
    .ram       (ram_if),
    .busy      (busy),
    .done      (done),
    .trig_addr (trig_addr),
    .start_addr(start_addr),
    .fill_cnt  (fill_cnt)
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  int            sk     = 0;
  exp_t          exp_q[$];
  exp_t          mon_e;
  logic [AW-1:0] exp_addr = '0;

  function automatic logic [DW-1:0] mk(int k);
    return {26'(k), 32'(k * 3 + 1), ~32'(k)};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [95:0] act, logic [95:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Present one sample; when it should be written, queue the expected write.
  task automatic feed(logic t, logic w);
    din  = mk(sk);
    trig = t;
    if (w) begin
      exp_q.push_back('{exp_addr, mk(sk)});
      exp_addr = exp_addr + AW'(1);
    end
    sk++;
  endtask

  task automatic do_arm(int plen);
    arm      = 1'b1;
    post_len = AW'(plen);
    exp_addr = '0;
    cyc();
    arm = 1'b0;
  endtask

  // pre untriggered samples, one trigger sample, plen post samples.
  // rearm_at >= 0 injects an arm pulse (must be ignored) on that sample.
  task automatic capture(int pre, int plen, int rearm_at);
    do_arm(plen);
    for (int i = 0; i <= pre; i++) begin
      feed(i == pre, 1'b1);
      arm = (i == rearm_at);
      cyc();
    end
    arm  = 1'b0;
    trig = 1'b0;
    for (int j = 0; j < plen; j++) begin
      feed(1'b0, 1'b1);
      cyc();
    end
  endtask

  // Monitor: every visible write must match the head of the queue.
  always @(negedge clk) begin
    if (rst_n && ram_if.ram_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected: got write addr %0d, required no write", ram_if.ram_waddr);
      end else begin
        mon_e = exp_q.pop_front();
        if (ram_if.ram_waddr !== mon_e.addr || ram_if.ram_wdata !== mon_e.data) begin
          errors++;
          $display("FAIL write: got addr %0d data %0h, required addr %0d data %0h",
                   ram_if.ram_waddr, ram_if.ram_wdata, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 96'(busy), 96'd0);
    chk("rst_done", 96'(done), 96'd0);
    chk("rst_we", 96'(ram_if.ram_we), 96'd0);
    chk("rst_waddr", 96'(ram_if.ram_waddr), 96'd0);
    chk("rst_fill", 96'(fill_cnt), 96'd0);
    rst_n = 1'b1;
    cyc();
    cyc();
    chk("idle_busy", 96'(busy), 96'd0);

    // Trigger on 5th sample, post_len 3; a stray arm while ARMED is ignored
    capture(4, 3, 1);
    chk("a_done", 96'(done), 96'd1);
    chk("a_busy", 96'(busy), 96'd0);
    chk("a_last_waddr", 96'(ram_if.ram_waddr), 96'd7);
    chk("a_trig_addr", 96'(trig_addr), 96'd4);
    chk("a_fill", 96'(fill_cnt), 96'd8);
    chk("a_start", 96'(start_addr), 96'd0);
    // abort in DONE is ignored, results held
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    repeat (3) cyc();
    chk("a_done_hold", 96'(done), 96'd1);
    chk("a_fill_hold", 96'(fill_cnt), 96'd8);
    chk("a_trig_hold", 96'(trig_addr), 96'd4);

    // post_len 0: done right after the trigger sample
    capture(2, 0, -1);
    chk("b_done", 96'(done), 96'd1);
    chk("b_trig_addr", 96'(trig_addr), 96'd2);
    chk("b_last_waddr", 96'(ram_if.ram_waddr), 96'd2);
    chk("b_fill", 96'(fill_cnt), 96'd3);

    // abort together with trig in ARMED
    do_arm(5);
    for (int i = 0; i < 3; i++) begin
      feed(1'b0, 1'b1);
      cyc();
    end
    feed(1'b1, 1'b0);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("c_busy", 96'(busy), 96'd0);
    chk("c_done", 96'(done), 96'd0);
    for (int i = 0; i < 4; i++) begin
      feed(1'b1, 1'b0);
      cyc();
    end
    trig = 1'b0;
    chk("c_idle_busy", 96'(busy), 96'd0);
    capture(1, 1, -1);
    chk("c_restart_trig", 96'(trig_addr), 96'd1);
    chk("c_restart_fill", 96'(fill_cnt), 96'd3);

    // abort on what would be the final POST sample
    do_arm(2);
    feed(1'b1, 1'b1);
    cyc();
    feed(1'b0, 1'b1);
    cyc();
    feed(1'b0, 1'b0);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("d_done", 96'(done), 96'd0);
    chk("d_busy", 96'(busy), 96'd0);
    repeat (3) cyc();

    // reset pulse during POST
    do_arm(10);
    feed(1'b1, 1'b1);
    cyc();
    feed(1'b0, 1'b1);
    cyc();
    feed(1'b0, 1'b1);
    cyc();
    trig = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("e_busy", 96'(busy), 96'd0);
    chk("e_done", 96'(done), 96'd0);
    chk("e_we", 96'(ram_if.ram_we), 96'd0);
    chk("e_waddr", 96'(ram_if.ram_waddr), 96'd0);
    chk("e_wdata", 96'(ram_if.ram_wdata), 96'd0);
    chk("e_trig_addr", 96'(trig_addr), 96'd0);
    chk("e_fill", 96'(fill_cnt), 96'd0);
    cyc();
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      feed(1'b1, 1'b0);
      cyc();
    end
    trig = 1'b0;
    chk("e_after_busy", 96'(busy), 96'd0);

    // long capture with address wrap
    capture(20000, 100, -1);
    chk("f_done", 96'(done), 96'd1);
    chk("f_fill", 96'(fill_cnt), 96'd16384);
    chk("f_trig_addr", 96'(trig_addr), 96'd3616);
    chk("f_start", 96'(start_addr), 96'd3717);

`ifdef CWC_CAPTURE_QUAL_EN
    // qual toggling: trig on an unqualified cycle is ignored
    do_arm(4);
    for (int c = 0; c <= 10; c++) begin
      qual = (c % 2 == 0);
      feed((c == 1) || (c == 2), qual);
      cyc();
    end
    qual = 1'b1;
    trig = 1'b0;
    chk("g_done", 96'(done), 96'd1);
    chk("g_trig_addr", 96'(trig_addr), 96'd1);
    chk("g_fill", 96'(fill_cnt), 96'd6);
    chk("g_last_waddr", 96'(ram_if.ram_waddr), 96'd5);
`endif

    repeat (3) cyc();
    chk("queue_empty", 96'(exp_q.size()), 96'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
